alu_seq: RTL and testbench
==========================

# alu_seq

Registered, handshaked successor to the combinational ALU: an N-bit ALU with a start/done interface, result and flag registers, and three new operation groups. The new groups are logical and arithmetic shifts, an SLL with lost-bit detection, and an iterative shift-and-add unsigned multiplier. It sits between the datapath register file and the writeback stage. The original seven operations keep their opcodes, now zero-extended to 4 bits.

## Interface
Parameters:
- N, default 8: operand width; power of two, N >= 4. Shift amount width is S = log2(N).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only when busy=0
- a  input  N  operand A, captured on the accepted start
- b  input  N  operand B, captured on the accepted start
- control  input  4  opcode, captured on the accepted start
- busy  output  1  multiply in progress; start is ignored while high
- done  output  1  one-cycle pulse; out, out_hi and flags valid from this cycle
- out  output  N  result (low half for MUL)
- out_hi  output  N  high half of the MUL product; 0 for all other ops
- overflow  output  1  carry, borrow, lost-bit or product overflow, per op
- zero  output  1  1 iff out == 0 (out_hi not considered)

## Operation
- Opcodes:
  - 0000 ADD: {overflow,out} = a+b.
  - 0001 SUB: {overflow,out} = a-b; borrow = 1 when a < b.
  - 0010 AND, 0011 OR, 0101 XOR, 0110 NOR: bitwise; overflow = 0.
  - 0100 SLT: out = 1 if a < b unsigned, else 0; overflow = 0.
  - 0111 SLL: out = a << b[S-1:0]; overflow = 1 if any bit shifted out is 1.
  - 1000 SRL: logical right shift by b[S-1:0]; overflow = 0.
  - 1001 SRA: arithmetic right shift by b[S-1:0] (sign fill from a[N-1]); overflow = 0.
  - 1010 MUL: unsigned 2N-bit product; out = low N bits, out_hi = high N bits, overflow = |out_hi.
  - 1011-1111: out = 0, out_hi = 0, overflow = 0; done still pulses.
- Upper bits of b above S are ignored for shifts. Shift amount 0 returns a unchanged with overflow = 0.
- The FSM has two states, IDLE and MUL.
  - In IDLE, start=1 captures a, b and control.
    - Non-MUL ops: the result is computed and registered on the same edge; the FSM stays in IDLE.
    - MUL: the FSM loads the multiplicand, multiplier, a 2N-bit accumulator and an iteration counter = 0, then enters MUL.
  - In MUL, each edge: if the multiplier LSB is 1, add the multiplicand into the accumulator; shift the multiplicand left and the multiplier right; increment the counter. After N iterations, load the results, pulse done and return to IDLE.
- out, out_hi, overflow and zero hold their last values until the next done.
- Operands arriving after capture do not affect an in-flight operation.

## Timing
- Reset values: out = 0, out_hi = 0, overflow = 0, zero = 1, done = 0, busy = 0; state IDLE, counter 0.
- Single-cycle ops: start accepted at edge k; done = 1 and results valid in the cycle after edge k; latency 1.
- MUL: start accepted at edge k; busy = 1 after edges k through k+N-1 (N cycles). At edge k+N: results loaded, done = 1, busy = 0. Latency N+1 edges.
- done is exactly one cycle wide, never asserted together with busy.
- start while busy = 1 is dropped; no queueing.
- start held high in the done cycle is accepted (FSM is in IDLE); back-to-back single-cycle ops give done every cycle.
- rst = 1 mid-MUL aborts the operation. All outputs take their reset values at that edge; no done is produced for the aborted op.
- rst takes priority over start on the same edge.

## Test plan
- N=8, ADD a=200, b=100, start 1 cycle -> next cycle done=1, out=0x2C, overflow=1, zero=0; following cycle done=0 and out holds.
- SUB a=5, b=7 -> out=0xFE, overflow=1. Then SUB a=9, b=9 -> out=0, zero=1, overflow=0.
- MUL a=15, b=17 -> busy high 8 cycles, done 9 edges after start, out=0xFF, out_hi=0, overflow=0. MUL a=16, b=16 -> out=0, out_hi=1, overflow=1, zero=1.
- SLL a=0x81, b=1 -> out=0x02, overflow=1. SRA a=0x80, b=0x0B (amount 3) -> out=0xF0. SRL a=0x80, b=3 -> out=0x10. Opcode 1111 -> out=0, done pulses.
- During MUL a=3, b=5, pulse start with ADD a=1, b=1 at cycle 3 -> ignored; result out=15, exactly one done.
- Start MUL a=0xFF, b=0xFF, assert rst at cycle 4 -> all outputs at reset values, no done. Then ADD a=1, b=2 -> out=3 one cycle later.

Source files
------------

// File: rtl/alu_seq.sv
// Registered N-bit ALU with start/done handshake: single-cycle logic/arithmetic/shift ops
// plus an iterative shift-and-add unsigned multiplier.
module alu_seq #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   control,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] out,
    output logic [N-1:0] out_hi,
    output logic         overflow,
    output logic         zero
);

    localparam int S = $clog2(N);
    localparam logic [S-1:0] LAST = S'(N - 1);

    typedef enum logic [3:0] {
        OP_ADD = 4'b0000,
        OP_SUB = 4'b0001,
        OP_AND = 4'b0010,
        OP_OR  = 4'b0011,
        OP_SLT = 4'b0100,
        OP_XOR = 4'b0101,
        OP_NOR = 4'b0110,
        OP_SLL = 4'b0111,
        OP_SRL = 4'b1000,
        OP_SRA = 4'b1001,
        OP_MUL = 4'b1010
    } op_t;

    typedef enum logic {
        IDLE,
        MUL
    } state_t;

    state_t         state, state_n;
    logic [2*N-1:0] mcand, mcand_n;
    logic [2*N-1:0] acc, acc_n, acc_sum;
    logic [N-1:0]   mplier, mplier_n;
    logic [S-1:0]   cnt, cnt_n;
    logic [N-1:0]   out_n, out_hi_n;
    logic           ov_n, zero_n, done_n;

    logic [S-1:0]   sh;
    logic [N:0]     sum, diff;
    logic [2*N-1:0] sll_full;
    logic [N-1:0]   alu_res;
    logic           alu_ov;

    assign sh       = b[S-1:0];
    assign sum      = {1'b0, a} + {1'b0, b};
    assign diff     = {1'b0, a} - {1'b0, b};
    assign sll_full = {{N{1'b0}}, a} << sh;
    assign busy     = (state == MUL);

    always_comb begin
        alu_res = '0;
        alu_ov  = 1'b0;
        case (op_t'(control))
            OP_ADD: begin
                alu_res = sum[N-1:0];
                alu_ov  = sum[N];
            end
            OP_SUB: begin
                alu_res = diff[N-1:0];
                alu_ov  = diff[N];
            end
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_SLT: alu_res = {{(N-1){1'b0}}, (a < b)};
            OP_XOR: alu_res = a ^ b;
            OP_NOR: alu_res = ~(a | b);
            OP_SLL: begin
                // Bits pushed past the top land in the upper half of the wide shift.
                alu_res = sll_full[N-1:0];
                alu_ov  = |sll_full[2*N-1:N];
            end
            OP_SRL: alu_res = a >> sh;
            OP_SRA: alu_res = $unsigned($signed(a) >>> sh);
            default: begin
                alu_res = '0;
                alu_ov  = 1'b0;
            end
        endcase
    end

    assign acc_sum = acc + (mplier[0] ? mcand : '0);

    always_comb begin
        state_n  = state;
        mcand_n  = mcand;
        mplier_n = mplier;
        acc_n    = acc;
        cnt_n    = cnt;
        out_n    = out;
        out_hi_n = out_hi;
        ov_n     = overflow;
        done_n   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (control == OP_MUL) begin
                        mcand_n  = {{N{1'b0}}, a};
                        mplier_n = b;
                        acc_n    = '0;
                        cnt_n    = '0;
                        state_n  = MUL;
                    end else begin
                        out_n    = alu_res;
                        out_hi_n = '0;
                        ov_n     = alu_ov;
                        done_n   = 1'b1;
                    end
                end
            end
            MUL: begin
                acc_n    = acc_sum;
                mcand_n  = mcand << 1;
                mplier_n = mplier >> 1;
                cnt_n    = cnt + 1'b1;
                // Final iteration: results come straight from this edge's accumulate.
                if (cnt == LAST) begin
                    out_n    = acc_sum[N-1:0];
                    out_hi_n = acc_sum[2*N-1:N];
                    ov_n     = |acc_sum[2*N-1:N];
                    done_n   = 1'b1;
                    cnt_n    = '0;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        zero_n = (out_n == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            cnt      <= '0;
            out      <= '0;
            out_hi   <= '0;
            overflow <= 1'b0;
            zero     <= 1'b1;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            mcand    <= mcand_n;
            mplier   <= mplier_n;
            acc      <= acc_n;
            cnt      <= cnt_n;
            out      <= out_n;
            out_hi   <= out_hi_n;
            overflow <= ov_n;
            zero     <= zero_n;
            done     <= done_n;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (N=8): directed stimulus pushes expected results,
// a negedge monitor pops one entry per done pulse.
module tb_alu_seq;

    logic       clk, rst, start;
    logic [7:0] a, b;
    logic [3:0] control;
    logic       busy, done, overflow, zero;
    logic [7:0] out, out_hi;

    alu_seq #(.N(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .control(control),
        .busy(busy), .done(done), .out(out), .out_hi(out_hi),
        .overflow(overflow), .zero(zero)
    );

    typedef struct packed {
        logic [7:0] o;
        logic [7:0] hi;
        logic       ov;
        logic       z;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            exp_t e;
            chk("done_busy_excl", {31'd0, busy}, 32'd0);
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 expected no pending result (out=0x%0h)", out);
            end else begin
                e = sbq.pop_front();
                chk("out",      {24'd0, out},      {24'd0, e.o});
                chk("out_hi",   {24'd0, out_hi},   {24'd0, e.hi});
                chk("overflow", {31'd0, overflow}, {31'd0, e.ov});
                chk("zero",     {31'd0, zero},     {31'd0, e.z});
            end
        end
    end

    // Drives one start cycle; called at posedge+1, returns at the next posedge+1.
    task automatic put(input logic [3:0] op, input logic [7:0] va, input logic [7:0] vb,
                       input logic push, input logic [7:0] eo, input logic [7:0] ehi,
                       input logic eov, input logic ez);
        start   = 1'b1;
        control = op;
        a       = va;
        b       = vb;
        if (push) sbq.push_back('{o: eo, hi: ehi, ov: eov, z: ez});
        @(posedge clk); #1;
    endtask

    task automatic idle();
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (sbq.size() == 0) break;
            @(posedge clk); #1;
        end
        if (sbq.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d pending results expected 0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_out"},    {24'd0, out},      32'd0);
        chk({tag, "_out_hi"}, {24'd0, out_hi},   32'd0);
        chk({tag, "_ovf"},    {31'd0, overflow}, 32'd0);
        chk({tag, "_zero"},   {31'd0, zero},     32'd1);
        chk({tag, "_done"},   {31'd0, done},     32'd0);
        chk({tag, "_busy"},   {31'd0, busy},     32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1);
    end

    initial begin
        int bcnt;
        logic seen;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; control = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        rst = 1'b0;
        @(posedge clk); #1;

        // ADD with carry, then done must drop and out hold.
        put(4'b0000, 8'd200, 8'd100, 1'b1, 8'h2C, 8'h00, 1'b1, 1'b0);
        idle();
        @(posedge clk); #1;
        chk("add_done_drop", {31'd0, done}, 32'd0);
        chk("add_out_hold", {24'd0, out}, 32'h2C);
        drain();

        put(4'b0001, 8'd5, 8'd7, 1'b1, 8'hFE, 8'h00, 1'b1, 1'b0);
        idle(); drain();
        put(4'b0001, 8'd9, 8'd9, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1);
        idle(); drain();

        // Bitwise, SLT, shifts, unused opcode; issued back-to-back.
        put(4'b0010, 8'hF0, 8'h3C, 1'b1, 8'h30, 8'h00, 1'b0, 1'b0);
        put(4'b0011, 8'hF0, 8'h0F, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b0);
        put(4'b0101, 8'hFF, 8'h0F, 1'b1, 8'hF0, 8'h00, 1'b0, 1'b0);
        put(4'b0110, 8'hF0, 8'h0F, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1);
        put(4'b0100, 8'd3,  8'd5,  1'b1, 8'h01, 8'h00, 1'b0, 1'b0);
        put(4'b0100, 8'd5,  8'd3,  1'b1, 8'h00, 8'h00, 1'b0, 1'b1);
        put(4'b0111, 8'h81, 8'h01, 1'b1, 8'h02, 8'h00, 1'b1, 1'b0);
        put(4'b0111, 8'h81, 8'h08, 1'b1, 8'h81, 8'h00, 1'b0, 1'b0);
        put(4'b1001, 8'h80, 8'h0B, 1'b1, 8'hF0, 8'h00, 1'b0, 1'b0);
        put(4'b1000, 8'h80, 8'h03, 1'b1, 8'h10, 8'h00, 1'b0, 1'b0);
        put(4'b1111, 8'hAA, 8'h55, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1);
        idle(); drain();

        // MUL 15*17 with busy-cycle count.
        put(4'b1010, 8'd15, 8'd17, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b0);
        idle();
        bcnt = 0; seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (done) begin seen = 1'b1; break; end
            if (busy) bcnt++;
            @(posedge clk); #1;
        end
        chk("mul_done_seen", {31'd0, seen}, 32'd1);
        chk("mul_busy_cycles", bcnt, 32'd8);
        drain();

        put(4'b1010, 8'd16, 8'd16, 1'b1, 8'h00, 8'h01, 1'b1, 1'b1);
        idle(); drain();

        // Start during busy must be dropped; one done only.
        put(4'b1010, 8'd3, 8'd5, 1'b1, 8'd15, 8'h00, 1'b0, 1'b0);
        idle();
        @(posedge clk); #1;
        put(4'b0000, 8'd1, 8'd1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        idle(); drain();
        repeat (4) @(posedge clk);
        #1;

        // Reset mid-MUL aborts with no done.
        put(4'b1010, 8'hFF, 8'hFF, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        idle();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk_reset_vals("abort");
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        put(4'b0000, 8'd1, 8'd2, 1'b1, 8'd3, 8'h00, 1'b0, 1'b0);
        idle(); drain();
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
